mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS-subset datapath: PC, IM, GPR, ALU, DM, NPC.
- Replaces the single-cycle combinational decoder with a state machine that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives instruction-register load and one PC update per instruction.
- Waits on a ready handshake for variable-latency data memory.
- Counts retired instructions.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- op  input  6  opcode from the latched instruction register
- funct  input  6  function field from the latched instruction register
- mem_ready  input  1  data memory has completed the current access this cycle
- ir_write  output  1  load the instruction register from IM
- pc_write  output  1  load PC from NPC this cycle
- reg_write  output  1  GPR write enable
- mem_req  output  1  data memory access request
- mem_write  output  1  data memory write (valid only with mem_req)
- regdst  output  2  destination select: 00 rt, 01 rd, 10 r31
- aluscr  output  1  ALU B select: 1 immediate, 0 rt
- extiop  output  1  immediate extension: 1 sign, 0 zero
- mem2reg  output  2  writeback source: 00 pc+4, 01 ALU, 10 memory
- snpc  output  2  NPC select: 00 branch, 01 jump, 10 register, 11 sequential
- aluop  output  5  ALU operation, existing codes 00000..01010
- illegal  output  1  one-cycle pulse on an unsupported op/funct
- state  output  4  current state, for debug
- retired  output  RETIRE_W  count of completed legal instructions

Behaviour:
- States (4-bit encoding):
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6
  - WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, JREG=11, ILLEGAL=12
- Reset low (async): state=FETCH, retired=0. Outputs take FETCH decode. PC is held by its own reset, so ir_write=1 during reset is harmless.
- State register and counter update on the rising clock edge. All outputs are combinational decode of state plus op/funct, which are stable from DECODE onward.
- Defaults in every state: ir_write=0, pc_write=0, reg_write=0, mem_req=0, mem_write=0, regdst=01, aluscr=0, extiop=0, mem2reg=01, snpc=11, aluop=00000, illegal=0.
- FETCH: ir_write=1 -> DECODE.
- DECODE dispatch:
  - R-type addu/subu/add/and/or/slt -> EXEC_R
  - jr (op 000000, funct 001000) -> JREG
  - addi/addiu/andi/ori/lui -> EXEC_I
  - lw/sw -> MEM_ADDR
  - beq -> BRANCH
  - j/jal -> JUMP
  - anything else -> ILLEGAL
- EXEC_R: aluop per funct (addu 00000, subu 00001, add 00010, and 00011, or 00100, slt 00101) -> WB_ALU.
- EXEC_I: aluscr=1; aluop addi 00110, addiu 00111, andi 01000, ori 01001, lui 01010; extiop=1 for addi/addiu only -> WB_ALU.
- WB_ALU: aluop and aluscr held from the execute state; regdst=01 for R-type, 00 for I-type; reg_write=1, mem2reg=01, pc_write=1, snpc=11 -> FETCH.
- MEM_ADDR: aluop=00110, aluscr=1, extiop=1 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: address controls held; mem_req=1.
  - Stays while mem_ready=0.
  - On mem_ready=1 -> WB_MEM.
- MEM_WR: address controls held; mem_req=1, mem_write=1.
  - Stays while mem_ready=0.
  - On mem_ready=1: pc_write=1 in the same cycle -> FETCH.
- WB_MEM: regdst=00, mem2reg=10, reg_write=1, pc_write=1 -> FETCH.
- BRANCH: aluop=00001, aluscr=0, extiop=1, snpc=00, pc_write=1 -> FETCH. NPC resolves taken/not-taken from zero.
- JUMP: snpc=01, pc_write=1.
  - jal additionally: reg_write=1, regdst=10, mem2reg=00.
  - -> FETCH.
- JREG: snpc=10, pc_write=1 -> FETCH.
- ILLEGAL: illegal=1, pc_write=1, snpc=11 (instruction skipped), no other writes -> FETCH. Not counted in retired.
- retired increments on every cycle with pc_write=1 outside ILLEGAL.
- Cycle counts:
  - beq, j, jal, jr: 3
  - R-type, I-ALU: 4
  - sw: 4+N wait cycles
  - lw: 5+N wait cycles
  - illegal: 3
- mem_ready outside MEM_RD/MEM_WR is ignored.
- Reset asserted mid-access: state returns to FETCH immediately and mem_req drops asynchronously. A partially waited access is abandoned.
- Exactly one pc_write per instruction. reg_write and mem_write are never asserted in the same cycle.

Decomposition:
- Shared package mc_pkg:
  - state encodings
  - aluop codes
  - snpc, regdst and mem2reg select codes
  - opcode and funct constants
- mc_pkg is shared with the ALU and NPC.
- One natural sub-module: mc_decode, the combinational output decode from state, op and funct. The FSM and counter stay in mc_ctrl.

Test Plan:
- Reset release, then addu (op 0, funct 100001) with mem_ready=0: state sequence 0,1,2,7,0. In state 7: reg_write=1, regdst=01, pc_write=1. retired=1.
- lw (op 100011) with mem_ready held low 3 cycles: state sequence 0,1,4,5,5,5,5,8,0. mem_req=1 for all 4 cycles in state 5, mem_write=0. In state 8: reg_write=1, mem2reg=10. Total 8 cycles.
- sw (op 101011) with mem_ready=1 immediately: state sequence 0,1,4,6,0. mem_write=1 and pc_write=1 in state 6. reg_write never 1.
- jal (op 000011): state sequence 0,1,10,0. In state 10: snpc=01, regdst=10, mem2reg=00, reg_write=1. beq (op 000100): state 9 with snpc=00, aluop=00001, reg_write=0.
- op 111111: state sequence 0,1,12,0. illegal pulses for 1 cycle, pc_write=1, retired unchanged.
- Assert reset while in MEM_RD waiting: state=0 and mem_req=0 asynchronously, retired=0. After release, normal fetch resumes.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path (states, ALU ops, mux selects, opcodes).
// Also used by the ALU and NPC, so codes here must stay stable.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JREG     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [4:0] ALU_ADDU  = 5'b00000;
    localparam logic [4:0] ALU_SUBU  = 5'b00001;
    localparam logic [4:0] ALU_ADD   = 5'b00010;
    localparam logic [4:0] ALU_AND   = 5'b00011;
    localparam logic [4:0] ALU_OR    = 5'b00100;
    localparam logic [4:0] ALU_SLT   = 5'b00101;
    localparam logic [4:0] ALU_ADDI  = 5'b00110;
    localparam logic [4:0] ALU_ADDIU = 5'b00111;
    localparam logic [4:0] ALU_ANDI  = 5'b01000;
    localparam logic [4:0] ALU_ORI   = 5'b01001;
    localparam logic [4:0] ALU_LUI   = 5'b01010;

    localparam logic [1:0] SNPC_BRANCH = 2'b00;
    localparam logic [1:0] SNPC_JUMP   = 2'b01;
    localparam logic [1:0] SNPC_REG    = 2'b10;
    localparam logic [1:0] SNPC_SEQ    = 2'b11;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] M2R_PC4 = 2'b00;
    localparam logic [1:0] M2R_ALU = 2'b01;
    localparam logic [1:0] M2R_MEM = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    function automatic logic [4:0] r_aluop(input logic [5:0] funct);
        case (funct)
            FN_ADDU: r_aluop = ALU_ADDU;
            FN_SUBU: r_aluop = ALU_SUBU;
            FN_ADD:  r_aluop = ALU_ADD;
            FN_AND:  r_aluop = ALU_AND;
            FN_OR:   r_aluop = ALU_OR;
            FN_SLT:  r_aluop = ALU_SLT;
            default: r_aluop = ALU_ADDU;
        endcase
    endfunction

    function automatic logic [4:0] i_aluop(input logic [5:0] op);
        case (op)
            OP_ADDI:  i_aluop = ALU_ADDI;
            OP_ADDIU: i_aluop = ALU_ADDIU;
            OP_ANDI:  i_aluop = ALU_ANDI;
            OP_ORI:   i_aluop = ALU_ORI;
            OP_LUI:   i_aluop = ALU_LUI;
            default:  i_aluop = ALU_ADDU;
        endcase
    endfunction

    // State entered from DECODE; anything unrecognised goes to ILLEGAL.
    function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_ADD, FN_AND, FN_OR, FN_SLT: dispatch = S_EXEC_R;
                    FN_JR:   dispatch = S_JREG;
                    default: dispatch = S_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: dispatch = S_EXEC_I;
            OP_LW, OP_SW: dispatch = S_MEM_ADDR;
            OP_BEQ:       dispatch = S_BRANCH;
            OP_J, OP_JAL: dispatch = S_JUMP;
            default:      dispatch = S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational datapath-control decode from the current state plus the latched op/funct.
// Zero latency; mem_ready only matters in MEM_WR, where it gates the PC update.
module mc_decode
    import mc_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic [1:0] regdst_o,
    output logic       aluscr_o,
    output logic       extiop_o,
    output logic [1:0] mem2reg_o,
    output logic [1:0] snpc_o,
    output logic [4:0] aluop_o,
    output logic       illegal_o
);

    logic is_rtype;
    assign is_rtype = (op_i == OP_RTYPE);

    always_comb begin
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        reg_write_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        regdst_o    = REGDST_RD;
        aluscr_o    = 1'b0;
        extiop_o    = 1'b0;
        mem2reg_o   = M2R_ALU;
        snpc_o      = SNPC_SEQ;
        aluop_o     = ALU_ADDU;
        illegal_o   = 1'b0;
        case (state_t'(state_i))
            S_FETCH:  ir_write_o = 1'b1;
            S_EXEC_R: aluop_o = r_aluop(funct_i);
            S_EXEC_I: begin
                aluscr_o = 1'b1;
                aluop_o  = i_aluop(op_i);
                extiop_o = (op_i == OP_ADDI) || (op_i == OP_ADDIU);
            end
            // ALU inputs re-derived from op/funct so the result is still valid at writeback
            S_WB_ALU: begin
                aluop_o     = is_rtype ? r_aluop(funct_i) : i_aluop(op_i);
                aluscr_o    = !is_rtype;
                regdst_o    = is_rtype ? REGDST_RD : REGDST_RT;
                reg_write_o = 1'b1;
                pc_write_o  = 1'b1;
            end
            S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
                aluop_o  = ALU_ADDI;
                aluscr_o = 1'b1;
                extiop_o = 1'b1;
                if (state_t'(state_i) == S_MEM_RD) begin
                    mem_req_o = 1'b1;
                end else if (state_t'(state_i) == S_MEM_WR) begin
                    mem_req_o   = 1'b1;
                    mem_write_o = 1'b1;
                    pc_write_o  = mem_ready_i;
                end
            end
            S_WB_MEM: begin
                regdst_o    = REGDST_RT;
                mem2reg_o   = M2R_MEM;
                reg_write_o = 1'b1;
                pc_write_o  = 1'b1;
            end
            S_BRANCH: begin
                aluop_o    = ALU_SUBU;
                extiop_o   = 1'b1;
                snpc_o     = SNPC_BRANCH;
                pc_write_o = 1'b1;
            end
            S_JUMP: begin
                snpc_o     = SNPC_JUMP;
                pc_write_o = 1'b1;
                if (op_i == OP_JAL) begin
                    reg_write_o = 1'b1;
                    regdst_o    = REGDST_R31;
                    mem2reg_o   = M2R_PC4;
                end
            end
            S_JREG: begin
                snpc_o     = SNPC_REG;
                pc_write_o = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_o  = 1'b1;
                pc_write_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback FSM plus retired-instruction counter.
// 3..5 cycles per instruction; MEM_RD/MEM_WR stall until mem_ready, reset abandons any pending access.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic                mem_req,
    output logic                mem_write,
    output logic [1:0]          regdst,
    output logic                aluscr,
    output logic                extiop,
    output logic [1:0]          mem2reg,
    output logic [1:0]          snpc,
    output logic [4:0]          aluop,
    output logic                illegal,
    output logic [3:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    state_t              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    mc_decode u_decode (
        .state_i     (state_q),
        .op_i        (op),
        .funct_i     (funct),
        .mem_ready_i (mem_ready),
        .ir_write_o  (ir_write),
        .pc_write_o  (pc_write),
        .reg_write_o (reg_write),
        .mem_req_o   (mem_req),
        .mem_write_o (mem_write),
        .regdst_o    (regdst),
        .aluscr_o    (aluscr),
        .extiop_o    (extiop),
        .mem2reg_o   (mem2reg),
        .snpc_o      (snpc),
        .aluop_o     (aluop),
        .illegal_o   (illegal)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE:   state_d = dispatch(op, funct);
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            default:    state_d = S_FETCH;
        endcase
    end

    // Skipped illegal instructions also update PC but are not retirements.
    always_comb begin
        retired_d = retired_q;
        if (pc_write && (state_q != S_ILLEGAL)) begin
            retired_d = retired_q + RETIRE_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomised self-checking bench for mc_ctrl against an instruction-level reference model.
module tb_mc_ctrl;

    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4;
    localparam int C_J = 5, C_JAL = 6, C_JR = 7, C_ILL = 8;
    localparam int NTAB = 21;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op = '0, funct = '0;
    logic        mem_ready = 1'b0;
    logic        ir_write, pc_write, reg_write, mem_req, mem_write;
    logic [1:0]  regdst, mem2reg, snpc;
    logic        aluscr, extiop, illegal;
    logic [4:0]  aluop;
    logic [3:0]  state;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;
    int exp_retired = 0;

    // Observations of the last executed instruction
    string       obs_seq;
    int          obs_ncyc, cnt_pc, cnt_rw, cnt_req, cnt_mw, cnt_ill, cnt_ir, cnt_both;
    logic [14:0] obs_key;
    logic        obs_ext;
    logic        timed_out;

    // Instruction table: op, funct, class, expected ALU code at writeback
    logic [5:0] t_op  [NTAB];
    logic [5:0] t_fn  [NTAB];
    int         t_cls [NTAB];
    logic [4:0] t_alu [NTAB];

    mc_ctrl #(.RETIRE_W(32)) dut (
        .clock(clock), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .mem_req(mem_req),
        .mem_write(mem_write), .regdst(regdst), .aluscr(aluscr), .extiop(extiop),
        .mem2reg(mem2reg), .snpc(snpc), .aluop(aluop), .illegal(illegal),
        .state(state), .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic set_entry(input int i, input logic [5:0] o, input logic [5:0] f,
                             input int c, input logic [4:0] a);
        t_op[i] = o; t_fn[i] = f; t_cls[i] = c; t_alu[i] = a;
    endtask

    task automatic init_table();
        set_entry(0,  6'b000000, 6'b100001, C_R, 5'b00000);
        set_entry(1,  6'b000000, 6'b100011, C_R, 5'b00001);
        set_entry(2,  6'b000000, 6'b100000, C_R, 5'b00010);
        set_entry(3,  6'b000000, 6'b100100, C_R, 5'b00011);
        set_entry(4,  6'b000000, 6'b100101, C_R, 5'b00100);
        set_entry(5,  6'b000000, 6'b101010, C_R, 5'b00101);
        set_entry(6,  6'b001000, 6'b000000, C_I, 5'b00110);
        set_entry(7,  6'b001001, 6'b000000, C_I, 5'b00111);
        set_entry(8,  6'b001100, 6'b000000, C_I, 5'b01000);
        set_entry(9,  6'b001101, 6'b000000, C_I, 5'b01001);
        set_entry(10, 6'b001111, 6'b000000, C_I, 5'b01010);
        set_entry(11, 6'b100011, 6'b000000, C_LW, 5'b00000);
        set_entry(12, 6'b101011, 6'b000000, C_SW, 5'b00000);
        set_entry(13, 6'b000100, 6'b000000, C_BEQ, 5'b00001);
        set_entry(14, 6'b000010, 6'b000000, C_J, 5'b00000);
        set_entry(15, 6'b000011, 6'b000000, C_JAL, 5'b00000);
        set_entry(16, 6'b000000, 6'b001000, C_JR, 5'b00000);
        set_entry(17, 6'b111111, 6'b000000, C_ILL, 5'b00000);
        set_entry(18, 6'b000000, 6'b111111, C_ILL, 5'b00000);
        set_entry(19, 6'b010000, 6'b000000, C_ILL, 5'b00000);
        set_entry(20, 6'b000000, 6'b100010, C_ILL, 5'b00000);
    endtask

    // Expected state trace of one instruction, from its class and memory wait count.
    function automatic string model_seq(input int cls, input int nw);
        string s;
        s = "0 1";
        case (cls)
            C_R:   s = {s, " 2 7"};
            C_I:   s = {s, " 3 7"};
            C_LW: begin
                s = {s, " 4"};
                for (int k = 0; k <= nw; k++) s = {s, " 5"};
                s = {s, " 8"};
            end
            C_SW: begin
                s = {s, " 4"};
                for (int k = 0; k <= nw; k++) s = {s, " 6"};
            end
            C_BEQ: s = {s, " 9"};
            C_J, C_JAL: s = {s, " 10"};
            C_JR:  s = {s, " 11"};
            default: s = {s, " 12"};
        endcase
        return s;
    endfunction

    function automatic int model_cycles(input int cls, input int nw);
        case (cls)
            C_R, C_I: return 4;
            C_LW:     return 5 + nw;
            C_SW:     return 4 + nw;
            default:  return 3;
        endcase
    endfunction

    // Controls in the final (PC-updating) cycle:
    // {reg_write, mem_write, regdst, mem2reg, snpc, aluscr, aluop, illegal}
    function automatic logic [14:0] model_key(input int cls, input logic [4:0] alu);
        case (cls)
            C_R:   return {1'b1, 1'b0, 2'b01, 2'b01, 2'b11, 1'b0, alu, 1'b0};
            C_I:   return {1'b1, 1'b0, 2'b00, 2'b01, 2'b11, 1'b1, alu, 1'b0};
            C_LW:  return {1'b1, 1'b0, 2'b00, 2'b10, 2'b11, 1'b0, 5'b00000, 1'b0};
            C_SW:  return {1'b0, 1'b1, 2'b01, 2'b01, 2'b11, 1'b1, 5'b00110, 1'b0};
            C_BEQ: return {1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 5'b00001, 1'b0};
            C_J:   return {1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 5'b00000, 1'b0};
            C_JAL: return {1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 1'b0, 5'b00000, 1'b0};
            C_JR:  return {1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 1'b0, 5'b00000, 1'b0};
            default: return {1'b0, 1'b0, 2'b01, 2'b01, 2'b11, 1'b0, 5'b00000, 1'b1};
        endcase
    endfunction

    // Runs one instruction starting from FETCH at a falling edge; ends at the next FETCH.
    task automatic exec_instr(input logic [5:0] o, input logic [5:0] f, input int nw);
        int waits;
        waits = nw;
        op = o; funct = f;
        obs_seq = ""; obs_ncyc = 0; timed_out = 1'b0;
        cnt_pc = 0; cnt_rw = 0; cnt_req = 0; cnt_mw = 0; cnt_ill = 0; cnt_ir = 0; cnt_both = 0;
        obs_key = '0; obs_ext = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (state == 4'd5 || state == 4'd6) mem_ready = (waits == 0);
            else mem_ready = 1'($urandom_range(0, 1));
            #1;
            obs_seq = (obs_ncyc == 0) ? $sformatf("%0d", state) : {obs_seq, $sformatf(" %0d", state)};
            obs_ncyc++;
            cnt_pc += int'(pc_write);
            cnt_rw += int'(reg_write);
            cnt_req += int'(mem_req);
            cnt_mw += int'(mem_write);
            cnt_ill += int'(illegal);
            cnt_ir += int'(ir_write);
            cnt_both += int'(reg_write && mem_write);
            obs_key = {reg_write, mem_write, regdst, mem2reg, snpc, aluscr, aluop, illegal};
            obs_ext = extiop;
            if ((state == 4'd5 || state == 4'd6) && waits > 0) waits--;
            @(posedge clock);
            @(negedge clock);
            if (state == 4'd0) break;
            if (k == 63) timed_out = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (state !== 4'd0 || retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: state=%0d retired=%0d, required 0/0", state, retired);
        end
        checks++;
        if ({ir_write, pc_write, mem_req, reg_write} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_outputs: ir/pc/req/rw=%b, required 1000", {ir_write, pc_write, mem_req, reg_write});
        end
        reset = 1'b1;
        exp_retired = 0;
    endtask

    task automatic test_addu();
        exec_instr(6'b000000, 6'b100001, 0);
        exp_retired++;
        checks++;
        if (obs_seq != model_seq(C_R, 0)) begin
            failures++;
            $display("FAIL addu_seq: got '%s' required '%s'", obs_seq, model_seq(C_R, 0));
        end
        checks++;
        if (obs_key !== model_key(C_R, 5'b00000) || cnt_pc !== 1) begin
            failures++;
            $display("FAIL addu_wb: key=%h pc_writes=%0d, required %h/1", obs_key, cnt_pc, model_key(C_R, 5'b00000));
        end
        checks++;
        if (retired !== 32'(exp_retired)) begin
            failures++;
            $display("FAIL addu_retired: got %0d required %0d", retired, exp_retired);
        end
    endtask

    task automatic test_mem();
        exec_instr(6'b100011, 6'($urandom), 3);
        exp_retired++;
        checks++;
        if (obs_seq != model_seq(C_LW, 3) || obs_ncyc != 8) begin
            failures++;
            $display("FAIL lw_seq: got '%s' (%0d cyc) required '%s' (8 cyc)", obs_seq, obs_ncyc, model_seq(C_LW, 3));
        end
        checks++;
        if (cnt_req !== 4 || cnt_mw !== 0 || obs_key !== model_key(C_LW, 5'b0)) begin
            failures++;
            $display("FAIL lw_ctrl: req=%0d mw=%0d key=%h, required 4/0/%h", cnt_req, cnt_mw, obs_key, model_key(C_LW, 5'b0));
        end
        exec_instr(6'b101011, 6'($urandom), 0);
        exp_retired++;
        checks++;
        if (obs_seq != model_seq(C_SW, 0)) begin
            failures++;
            $display("FAIL sw_seq: got '%s' required '%s'", obs_seq, model_seq(C_SW, 0));
        end
        checks++;
        if (cnt_mw !== 1 || cnt_rw !== 0 || cnt_pc !== 1 || obs_key !== model_key(C_SW, 5'b0)) begin
            failures++;
            $display("FAIL sw_ctrl: mw=%0d rw=%0d pc=%0d key=%h, required 1/0/1/%h", cnt_mw, cnt_rw, cnt_pc, obs_key, model_key(C_SW, 5'b0));
        end
    endtask

    task automatic test_jump_branch();
        exec_instr(6'b000011, 6'($urandom), 0);
        exp_retired++;
        checks++;
        if (obs_seq != model_seq(C_JAL, 0) || obs_key !== model_key(C_JAL, 5'b0)) begin
            failures++;
            $display("FAIL jal: seq '%s' key=%h, required '%s' %h", obs_seq, obs_key, model_seq(C_JAL, 0), model_key(C_JAL, 5'b0));
        end
        exec_instr(6'b000100, 6'($urandom), 0);
        exp_retired++;
        checks++;
        if (obs_seq != model_seq(C_BEQ, 0) || obs_key !== model_key(C_BEQ, 5'b0) || obs_ext !== 1'b1) begin
            failures++;
            $display("FAIL beq: seq '%s' key=%h ext=%b, required '%s' %h 1", obs_seq, obs_key, obs_ext, model_seq(C_BEQ, 0), model_key(C_BEQ, 5'b0));
        end
    endtask

    task automatic test_illegal();
        exec_instr(6'b111111, 6'($urandom), 0);
        checks++;
        if (obs_seq != model_seq(C_ILL, 0) || cnt_ill !== 1 || cnt_pc !== 1) begin
            failures++;
            $display("FAIL illegal: seq '%s' pulses=%0d pc=%0d, required '%s' 1 1", obs_seq, cnt_ill, cnt_pc, model_seq(C_ILL, 0));
        end
        checks++;
        if (retired !== 32'(exp_retired)) begin
            failures++;
            $display("FAIL illegal_retired: got %0d required %0d", retired, exp_retired);
        end
    endtask

    task automatic test_reset_mid_access();
        op = 6'b100011;
        mem_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (state == 4'd5) break;
            @(posedge clock);
            @(negedge clock);
        end
        checks++;
        if (state !== 4'd5 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_reach_mem_rd: state=%0d req=%b, required 5/1", state, mem_req);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || mem_req !== 1'b0 || retired !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset: state=%0d req=%b retired=%0d, required 0/0/0", state, mem_req, retired);
        end
        exp_retired = 0;
        @(negedge clock);
        reset = 1'b1;
        exec_instr(6'b000000, 6'b100101, 0);
        exp_retired++;
        checks++;
        if (obs_seq != model_seq(C_R, 0) || retired !== 32'(exp_retired)) begin
            failures++;
            $display("FAIL mid_resume: seq '%s' retired=%0d, required '%s' %0d", obs_seq, retired, model_seq(C_R, 0), exp_retired);
        end
    endtask

    task automatic test_random();
        int idx, nw, cls;
        logic [5:0] fn;
        for (int n = 0; n < 80; n++) begin
            idx = int'($urandom_range(0, NTAB - 1));
            nw = int'($urandom_range(0, 4));
            cls = t_cls[idx];
            fn = (t_op[idx] == 6'b000000) ? t_fn[idx] : 6'($urandom);
            exec_instr(t_op[idx], fn, nw);
            if (cls != C_ILL) exp_retired++;
            checks++;
            if (timed_out || obs_seq != model_seq(cls, nw) || obs_ncyc != model_cycles(cls, nw)) begin
                failures++;
                $display("FAIL rnd_seq[%0d] op=%b fn=%b n=%0d: got '%s' required '%s'", n, t_op[idx], fn, nw, obs_seq, model_seq(cls, nw));
            end
            checks++;
            if (obs_key !== model_key(cls, t_alu[idx])) begin
                failures++;
                $display("FAIL rnd_key[%0d] op=%b: got %h required %h", n, t_op[idx], obs_key, model_key(cls, t_alu[idx]));
            end
            checks++;
            if (cnt_pc !== 1 || cnt_ir !== 1 || cnt_both !== 0 || cnt_ill !== int'(cls == C_ILL)) begin
                failures++;
                $display("FAIL rnd_counts[%0d]: pc=%0d ir=%0d rw&mw=%0d ill=%0d, required 1/1/0/%0d", n, cnt_pc, cnt_ir, cnt_both, cnt_ill, int'(cls == C_ILL));
            end
            checks++;
            if (cnt_rw !== int'(cls == C_R || cls == C_I || cls == C_LW || cls == C_JAL)
                || cnt_req !== ((cls == C_LW || cls == C_SW) ? nw + 1 : 0)
                || cnt_mw !== ((cls == C_SW) ? nw + 1 : 0)) begin
                failures++;
                $display("FAIL rnd_mem[%0d] op=%b: rw=%0d req=%0d mw=%0d", n, t_op[idx], cnt_rw, cnt_req, cnt_mw);
            end
            checks++;
            if (retired !== 32'(exp_retired)) begin
                failures++;
                $display("FAIL rnd_retired[%0d]: got %0d required %0d", n, retired, exp_retired);
            end
        end
    endtask

    initial begin
        init_table();
        test_reset();
        test_addu();
        test_mem();
        test_jump_branch();
        test_illegal();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
